// File: rtl/alu_ex_stage.sv
// alu_ex_stage: RISC-V execute stage around alu_dp with a 2-entry skid buffer.
// Decodes funct3/funct7[5] into an alu_dp op, registers result/flags/branch
// decision, and hands them downstream over a valid/ready handshake.
//
// Ports (alu_ex_stage):
//   clk, rst_n                      clock (rising edge), async active-low reset
//   in_valid / in_ready             upstream handshake (in_ready registered)
//   in_funct3, in_funct7b5          instruction decode fields
//   in_is_branch, in_rd             branch marker, destination register
//   in_A, in_B                      operands
//   out_valid / out_ready           downstream handshake
//   out_R, out_flags, out_taken     result, {gt,lt,eq,ne}, branch decision
//   out_rd, out_illegal             destination (0 for branch/illegal), bad funct3
//
// Ports (alu_dp):
//   a, b      operands
//   op        0 add, 1 sub, 2 and, 3 or, 4 xor
//   r, flags  result and signed {gt,lt,eq,ne}

module alu_dp #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      op,
    output logic [XLEN-1:0] r,
    output logic [3:0]      flags
);

    always_comb begin
        r = '0;
        unique case (op)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            default: r = '0;
        endcase
    end

    // Signed compare so blt/bge follow RISC-V semantics.
    always_comb begin
        flags[3] = $signed(a) > $signed(b);
        flags[2] = $signed(a) < $signed(b);
        flags[1] = (a == b);
        flags[0] = (a != b);
    end

endmodule

module alu_ex_stage #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7b5,
    input  logic            in_is_branch,
    input  logic [RD_W-1:0] in_rd,
    input  logic [XLEN-1:0] in_A,
    input  logic [XLEN-1:0] in_B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_R,
    output logic [3:0]      out_flags,
    output logic            out_taken,
    output logic [RD_W-1:0] out_rd,
    output logic            out_illegal
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;

    typedef struct packed {
        logic [XLEN-1:0] r;
        logic [3:0]      flags;
        logic            taken;
        logic [RD_W-1:0] rd;
        logic            illegal;
    } exPkt_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } bufState_t;

    logic [2:0]      aluOp;
    logic            opLegal;
    logic [XLEN-1:0] aluR;
    logic [3:0]      aluFlags;
    logic            brLegal;
    logic            brTaken;
    exPkt_t          newPkt;

    bufState_t state;
    exPkt_t    mainPkt;
    exPkt_t    skidPkt;
    logic      inReadyQ;
    logic      outValidQ;
    logic      accept;
    logic      drain;

    // Op decode is kept apart from the taken/packet logic so that
    // the flags feedback does not form a combinational loop.
    always_comb begin
        aluOp   = OP_ADD;
        opLegal = 1'b0;
        if (in_is_branch) begin
            aluOp   = OP_SUB;
            opLegal = 1'b0;
        end else begin
            unique case (in_funct3)
                3'b000: begin
                    aluOp   = in_funct7b5 ? OP_SUB : OP_ADD;
                    opLegal = 1'b1;
                end
                3'b111: begin
                    aluOp   = OP_AND;
                    opLegal = 1'b1;
                end
                3'b110: begin
                    aluOp   = OP_OR;
                    opLegal = 1'b1;
                end
                3'b100: begin
                    aluOp   = OP_XOR;
                    opLegal = 1'b1;
                end
                default: begin
                    aluOp   = OP_ADD;
                    opLegal = 1'b0;
                end
            endcase
        end
    end

    alu_dp #(
        .XLEN (XLEN)
    ) uAluDp (
        .a     (in_A),
        .b     (in_B),
        .op    (aluOp),
        .r     (aluR),
        .flags (aluFlags)
    );

    always_comb begin
        brLegal = 1'b0;
        brTaken = 1'b0;
        unique case (in_funct3)
            3'b000: begin
                brLegal = 1'b1;
                brTaken = aluFlags[1];
            end
            3'b001: begin
                brLegal = 1'b1;
                brTaken = aluFlags[0];
            end
            3'b100: begin
                brLegal = 1'b1;
                brTaken = aluFlags[2];
            end
            3'b101: begin
                brLegal = 1'b1;
                brTaken = !aluFlags[2];
            end
            default: begin
                brLegal = 1'b0;
                brTaken = 1'b0;
            end
        endcase
    end

    // Illegal packets carry no result and no destination; flags are kept.
    always_comb begin
        newPkt       = '0;
        newPkt.flags = aluFlags;
        if (in_is_branch) begin
            newPkt.illegal = !brLegal;
            newPkt.r       = brLegal ? aluR : '0;
            newPkt.taken   = brLegal && brTaken;
            newPkt.rd      = '0;
        end else begin
            newPkt.illegal = !opLegal;
            newPkt.r       = opLegal ? aluR : '0;
            newPkt.taken   = 1'b0;
            newPkt.rd      = opLegal ? in_rd : '0;
        end
    end

    assign accept = in_valid && inReadyQ;
    assign drain  = outValidQ && out_ready;

    // Main register always feeds the outputs; skid only fills when the
    // main entry is stalled, so in_ready can stay a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            mainPkt   <= '0;
            skidPkt   <= '0;
            inReadyQ  <= 1'b1;
            outValidQ <= 1'b0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        mainPkt   <= newPkt;
                        outValidQ <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        mainPkt <= newPkt;
                    end else if (accept) begin
                        skidPkt  <= newPkt;
                        inReadyQ <= 1'b0;
                        state    <= TWO;
                    end else if (drain) begin
                        outValidQ <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                TWO: begin
                    if (drain) begin
                        mainPkt  <= skidPkt;
                        inReadyQ <= 1'b1;
                        state    <= ONE;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    inReadyQ  <= 1'b1;
                    outValidQ <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = inReadyQ;
    assign out_valid   = outValidQ;
    assign out_R       = mainPkt.r;
    assign out_flags   = mainPkt.flags;
    assign out_taken   = mainPkt.taken;
    assign out_rd      = mainPkt.rd;
    assign out_illegal = mainPkt.illegal;

endmodule
